// File: rtl/square_encoder.sv
// Walks a 9-bit board mask and emits one (row, col) pair per set square over
// valid/ready, in ascending or descending bit order, then pulses done.
module square_encoder #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] mask,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    output logic       is_onehot
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t     state, state_n;
    logic [8:0] pending, pending_n, rest;
    logic [3:0] k, count_n;
    logic [1:0] row_n, col_n, k_row, k_col;
    logic       valid_n, last_n, onehot_n, load;

    // Priority pick: the last match in the loop wins, so loop direction is
    // opposite to the scan order.
    generate
        if (LSB_FIRST) begin : g_lsb
            always_comb begin
                k = '0;
                for (int i = 8; i >= 0; i--)
                    if (pending[i]) k = 4'(i);
            end
        end else begin : g_msb
            always_comb begin
                k = '0;
                for (int i = 0; i < 9; i++)
                    if (pending[i]) k = 4'(i);
            end
        end
    endgenerate

    always_comb begin
        k_row = (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
        k_col = 2'(k - {2'b00, k_row} * 4'd3);
        rest  = pending & ~(9'd1 << k);
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        row_n     = row;
        col_n     = col;
        last_n    = last;
        valid_n   = out_valid;
        count_n   = count;
        onehot_n  = is_onehot;
        load      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n   = SCAN;
                pending_n = mask;
                count_n   = '0;
                onehot_n  = ($countones(mask) == 1);
            end
            SCAN: if (pending == '0) state_n = DONE;
                  else begin
                      load    = 1'b1;
                      state_n = EMIT;
                  end
            EMIT: if (out_ready) begin
                count_n = count + 4'd1;
                if (pending != '0) load = 1'b1;
                else begin
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Shared by SCAN and EMIT so back-to-back handshakes reload in one edge.
        if (load) begin
            row_n     = k_row;
            col_n     = k_col;
            pending_n = rest;
            last_n    = (rest == '0);
            valid_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            row       <= '0;
            col       <= '0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            is_onehot <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            out_valid <= valid_n;
            row       <= row_n;
            col       <= col_n;
            last      <= last_n;
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
            count     <= count_n;
            is_onehot <= onehot_n;
        end
    end

endmodule

// File: tb/tb_square_encoder.sv
// Scoreboard bench: runs ascending and descending encoders side by side on
// shared stimulus; expected pairs come from a list-based model of the mask.
module tb_square_encoder;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [8:0] mask;
    logic       ov_a, last_a, busy_a, done_a, oh_a;
    logic       ov_d, last_d, busy_d, done_d, oh_d;
    logic [1:0] row_a, col_a, row_d, col_d;
    logic [3:0] cnt_a, cnt_d;

    square_encoder #(.LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .out_ready(out_ready),
        .out_valid(ov_a), .row(row_a), .col(col_a), .last(last_a),
        .busy(busy_a), .done(done_a), .count(cnt_a), .is_onehot(oh_a));

    square_encoder #(.LSB_FIRST(1'b0)) dut_d (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .out_ready(out_ready),
        .out_valid(ov_d), .row(row_d), .col(col_d), .last(last_d),
        .busy(busy_d), .done(done_d), .count(cnt_d), .is_onehot(oh_d));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
    } pair_t;

    pair_t      qa[$], qd[$];
    int         vectors = 0, miscompares = 0;
    int         exp_cnt = 0;
    logic       exp_oh = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: list the set squares, coordinates by plain division.
    function automatic void model(input logic [8:0] m);
        int    idx[$];
        pair_t p;
        for (int b = 0; b < 9; b++) if (m[b]) idx.push_back(b);
        foreach (idx[i]) begin
            p.row = 2'(idx[i] / 3); p.col = 2'(idx[i] % 3); p.last = (i == idx.size() - 1);
            qa.push_back(p);
            p.row = 2'(idx[idx.size()-1-i] / 3); p.col = 2'(idx[idx.size()-1-i] % 3);
            qd.push_back(p);
        end
        exp_cnt = idx.size();
        exp_oh  = (idx.size() == 1);
    endfunction

    task automatic mon_one(input bit d, input logic ov, input logic [1:0] r, input logic [1:0] c,
                           input logic l, input logic dn, input logic [3:0] cn, input logic oh);
        pair_t e;
        int    qs;
        string tag;
        tag = d ? "msb" : "lsb";
        qs  = d ? qd.size() : qa.size();
        if (ov !== 1'b0 && ov !== 1'b1) check({tag, " valid_known"}, 32'(ov), 32'd0);
        if (ov === 1'b1) begin
            if (qs == 0) check({tag, " unexpected_pair"}, 32'd1, 32'd0);
            else begin
                e = d ? qd[0] : qa[0];
                check({tag, " row"},  32'(r), 32'(e.row));
                check({tag, " col"},  32'(c), 32'(e.col));
                check({tag, " last"}, 32'(l), 32'(e.last));
                check({tag, " count_during"}, 32'(cn), 32'(exp_cnt - qs));
                if (out_ready) begin
                    if (d) void'(qd.pop_front()); else void'(qa.pop_front());
                end
            end
        end
        if (dn === 1'b1) begin
            check({tag, " count_done"}, 32'(cn), 32'(exp_cnt));
            check({tag, " onehot"}, 32'(oh), 32'(exp_oh));
            check({tag, " pairs_left"}, 32'(qs), 32'd0);
        end
    endtask

    always @(negedge clk) if (rst === 1'b0) begin
        mon_one(1'b0, ov_a, row_a, col_a, last_a, done_a, cnt_a, oh_a);
        mon_one(1'b1, ov_d, row_d, col_d, last_d, done_d, cnt_d, oh_d);
    end

    task automatic check_zero(input string name);
        check({name, " a"}, {ov_a, row_a, col_a, last_a, busy_a, done_a, cnt_a, oh_a}, 32'd0);
        check({name, " d"}, {ov_d, row_d, col_d, last_d, busy_d, done_d, cnt_d, oh_d}, 32'd0);
    endtask

    // Called just after a rising edge E; start is sampled on edge E+1.
    // mode 0: ready high, 1: random ready, 2: ready low for `hold` valid cycles.
    task automatic run(input logic [8:0] m, input int mode, input int hold, input bit inject);
        int e0, n, vcyc, np;
        e0 = cyc;
        np = $countones(m);
        start = 1'b1; mask = m; model(m);
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : 1'b0;
        @(posedge clk); #1;
        start = 1'b0; mask = 9'($urandom);
        @(negedge clk);
        check("scan_busy", 32'(busy_a), 32'd1);
        check("scan_no_valid", 32'(ov_a), 32'd0);
        @(negedge clk);
        check("first_valid a", 32'(ov_a), 32'(m != 0));
        check("first_valid d", 32'(ov_d), 32'(m != 0));
        n = 0; vcyc = 0;
        while (1) begin
            if (done_a === 1'b1) break;
            if (n >= 300) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
            if (ov_a === 1'b1) vcyc++;
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = (vcyc >= hold);
            endcase
            if (inject) begin
                start = (n == 0);
                if (n == 0) mask = 9'h1FF;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_both", 32'(done_d), 32'd1);
        if (mode == 0) check("done_cycle", 32'(cyc - e0), 32'(2 + np));
        @(negedge clk);
        check("done_pulse", 32'(done_a), 32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("hold_count", 32'(cnt_a), 32'(exp_cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mask = '0; out_ready = 1'b0;
        #2;
        check_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        run(9'h001, 0, 0, 1'b0);
        check("onehot_001", 32'(oh_a), 32'd1);
        run(9'h1FF, 0, 0, 1'b0);
        check("onehot_1ff", 32'(oh_a), 32'd0);
        run(9'h000, 0, 0, 1'b0);
        check("count_empty", 32'(cnt_a), 32'd0);
        run(9'h110, 2, 5, 1'b0);
        run(9'h005, 0, 0, 1'b1);
        check("count_005", 32'(cnt_d), 32'd2);

        // Reset while a pair is waiting for the consumer.
        start = 1'b1; mask = 9'h0FF; model(9'h0FF); out_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("emit_before_rst", 32'(ov_a), 32'd1);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        qa.delete(); qd.delete();
        @(posedge clk); #1;
        check_zero("reset_hold");
        rst = 1'b0;
        run(9'h100, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++)
            run(9'($urandom), int'($urandom % 3), int'($urandom_range(1, 4)), 1'($urandom % 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
